// File: rtl/alu_rs.sv
// alu_rs: four-entry reservation station in front of the combinational ALU.
// Buffers dispatched micro-ops, wakes operands from the CDB, issues the
// lowest ready entry into registered ALU operand latches and captures the
// ALU outputs into a one-cycle tagged result broadcast.
module alu_rs #(
    parameter int RS_LOG = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    // dispatch
    input  logic             disp_valid,
    input  logic [4:0]       disp_op,
    input  logic [31:0]      disp_addr,
    input  logic             disp_len,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    output logic             full,
    // wake-up bus
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    // ALU operand latches
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [31:0]      alu_addr,
    output logic [4:0]       alu_op,
    output logic             alu_len,
    // ALU outputs
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_jalr_done,
    input  logic [31:0]      alu_jalr_addr,
    // result broadcast
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_value,
    output logic             out_jalr,
    output logic [31:0]      out_jalr_addr
);
    localparam int RS_N   = 1 << RS_LOG;
    // vld_pipe[0] = op sitting in the ALU latches, vld_pipe[1] = result on out_*
    localparam int STAGES = 1;

    typedef struct packed {
        logic             busy;
        logic [4:0]       op;
        logic [31:0]      addr;
        logic             len;
        logic [TAG_W-1:0] tag;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_busy;
        logic [TAG_W-1:0] qj;
        logic             qk_busy;
        logic [TAG_W-1:0] qk;
    } rs_entry_t;

    rs_entry_t [RS_N-1:0] ent;
    rs_entry_t [RS_N-1:0] ent_nxt;
    logic [RS_N-1:0]      busy_vec;
    logic [RS_N-1:0]      ready_vec;
    logic [RS_LOG-1:0]    free_idx;
    logic [RS_LOG-1:0]    iss_idx;
    logic                 iss_hit;
    logic                 disp_acc;
    logic                 fwd_j;
    logic                 fwd_k;
    logic [STAGES:0]      vld_pipe;
    logic [TAG_W-1:0]     exec_tag;
    logic                 exec_valid;

    // zero flag is not part of the broadcast; branch outcome rides in result bit 0
    logic unused_zero;
    assign unused_zero = alu_zero;

    assign exec_valid = vld_pipe[0];
    assign out_valid  = vld_pipe[STAGES];
    assign full       = &busy_vec;
    assign disp_acc   = disp_valid && !full;
    // operand produced on the CDB in the same cycle as its dispatch
    assign fwd_j      = disp_qj_busy && cdb_valid && (cdb_tag == disp_qj);
    assign fwd_k      = disp_qk_busy && cdb_valid && (cdb_tag == disp_qk);

    // status vectors and lowest-index free / ready selection from registered state
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        free_idx  = '0;
        iss_idx   = '0;
        iss_hit   = 1'b0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
            if (!ent[i].busy) free_idx = RS_LOG'(i);
            if (ready_vec[i]) begin
                iss_hit = 1'b1;
                iss_idx = RS_LOG'(i);
            end
        end
    end

    // per-entry next state: wake-up, release on issue, dispatch write, flush
    always_comb begin
        ent_nxt = ent;
        for (int i = 0; i < RS_N; i++) begin
            if (ent[i].busy && cdb_valid && ent[i].qj_busy && cdb_tag == ent[i].qj) begin
                ent_nxt[i].qj_busy = 1'b0;
                ent_nxt[i].vj      = cdb_value;
            end
            if (ent[i].busy && cdb_valid && ent[i].qk_busy && cdb_tag == ent[i].qk) begin
                ent_nxt[i].qk_busy = 1'b0;
                ent_nxt[i].vk      = cdb_value;
            end
            if (iss_hit && iss_idx == RS_LOG'(i)) ent_nxt[i].busy = 1'b0;
            if (disp_acc && free_idx == RS_LOG'(i)) begin
                ent_nxt[i].busy    = 1'b1;
                ent_nxt[i].op      = disp_op;
                ent_nxt[i].addr    = disp_addr;
                ent_nxt[i].len     = disp_len;
                ent_nxt[i].tag     = disp_tag;
                ent_nxt[i].vj      = fwd_j ? cdb_value : disp_vj;
                ent_nxt[i].vk      = fwd_k ? cdb_value : disp_vk;
                ent_nxt[i].qj_busy = disp_qj_busy && !fwd_j;
                ent_nxt[i].qk_busy = disp_qk_busy && !fwd_k;
                ent_nxt[i].qj      = disp_qj;
                ent_nxt[i].qk      = disp_qk;
            end
            if (flush) ent_nxt[i].busy = 1'b0;
        end
    end

    // entry storage; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      ent <= '0;
        else if (rdy_in) ent <= ent_nxt;
    end

    // ALU operand latches load on issue and otherwise hold
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_op1  <= '0;
            alu_op2  <= '0;
            alu_addr <= '0;
            alu_op   <= '0;
            alu_len  <= 1'b0;
            exec_tag <= '0;
        end else if (rdy_in && !flush && iss_hit) begin
            alu_op1  <= ent[iss_idx].vj;
            alu_op2  <= ent[iss_idx].vk;
            alu_addr <= ent[iss_idx].addr;
            alu_op   <= ent[iss_idx].op;
            alu_len  <= ent[iss_idx].len;
            exec_tag <= ent[iss_idx].tag;
        end
    end

    // issue -> execute -> broadcast valid shift register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      vld_pipe <= '0;
        else if (rdy_in) vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1:0], iss_hit};
    end

    // capture ALU outputs for the one-cycle broadcast
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_tag       <= '0;
            out_value     <= '0;
            out_jalr      <= 1'b0;
            out_jalr_addr <= '0;
        end else if (rdy_in && !flush && exec_valid) begin
            out_tag       <= exec_tag;
            out_value     <= alu_result;
            out_jalr      <= alu_jalr_done;
            out_jalr_addr <= alu_jalr_addr;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs with a small behavioural ALU.
module tb_alu_rs;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_BEQ = 5'd2, OP_JALR = 5'd3;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        disp_valid, disp_len, disp_qj_busy, disp_qk_busy;
    logic [4:0]  disp_op;
    logic [31:0] disp_addr, disp_vj, disp_vk;
    logic [3:0]  disp_tag, disp_qj, disp_qk;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [31:0] alu_op1, alu_op2, alu_addr;
    logic [4:0]  alu_op;
    logic        alu_len;
    logic [31:0] alu_result, alu_jalr_addr;
    logic        alu_zero, alu_jalr_done;
    logic        out_valid, out_jalr;
    logic [3:0]  out_tag;
    logic [31:0] out_value, out_jalr_addr;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        jalr;
        logic [31:0] jaddr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_in = ~clk_in;

    alu_rs #(.RS_LOG(2), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_addr(disp_addr),
        .disp_len(disp_len), .disp_tag(disp_tag), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_addr(alu_addr),
        .alu_op(alu_op), .alu_len(alu_len),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_jalr_done(alu_jalr_done), .alu_jalr_addr(alu_jalr_addr),
        .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value),
        .out_jalr(out_jalr), .out_jalr_addr(out_jalr_addr)
    );

    // behavioural combinational ALU
    always_comb begin
        alu_result    = '0;
        alu_jalr_done = 1'b0;
        alu_jalr_addr = '0;
        case (alu_op)
            OP_ADD: alu_result = alu_op1 + alu_op2;
            OP_SUB: alu_result = alu_op1 - alu_op2;
            OP_BEQ: alu_result = {31'b0, alu_op1 == alu_op2};
            OP_JALR: begin
                alu_result    = alu_addr + (alu_len ? 32'd4 : 32'd2);
                alu_jalr_done = 1'b1;
                alu_jalr_addr = (alu_op1 + alu_op2) & ~32'd1;
            end
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                        input logic [3:0] tag, input logic [31:0] addr, input logic len);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj_busy = qjb; disp_qj = qj; disp_qk_busy = qkb; disp_qk = qk;
        disp_tag = tag; disp_addr = addr; disp_len = len;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    endtask

    task automatic push(input logic [3:0] t, input logic [31:0] v, input logic j, input logic [31:0] ja);
        exp_t e;
        e.tag = t; e.val = v; e.jalr = j; e.jaddr = ja;
        sb.push_back(e);
    endtask

    // scoreboard: every broadcast must match the oldest expected result
    always @(negedge clk_in) begin
        if (rst_in === 1'b0 && out_valid === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("out_tag", out_tag, mon_e.tag);
                chk("out_value", out_value, mon_e.val);
                chk("out_jalr", out_jalr, mon_e.jalr);
                chk("out_jalr_addr", out_jalr_addr, mon_e.jaddr);
            end
        end
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        idle();
        disp(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        cdb_tag = '0; cdb_value = '0;
        step(); step();
        rst_in = 1'b0;
        #1;
        chk("rst_full", full, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_jalr", out_jalr, 0);
        chk("rst_out_jalr_addr", out_jalr_addr, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_op2", alu_op2, 0);
        chk("rst_alu_addr", alu_addr, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_len", alu_len, 0);

        // reset with one op executing and one waiting: both discarded
        step();
        disp(OP_ADD, 1, 1, 0, 0, 0, 0, 4'd1, 0, 1);
        step();
        disp(OP_ADD, 0, 1, 1, 4'd5, 0, 0, 4'd2, 0, 1);
        step();
        idle();
        #2 rst_in = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_alu_op1", alu_op1, 0);
        chk("rst_mid_full", full, 0);
        step();
        rst_in = 1'b0;
        cdb(4'd5, 32'd1);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_quiet", out_valid, 0);
        end

        // ADD with ready operands: result two edges after dispatch, one cycle wide
        disp(OP_ADD, 5, 7, 0, 0, 0, 0, 4'd3, 0, 1);
        push(4'd3, 32'd12, 0, 0);
        step(); idle();
        chk("add_lat_e0", out_valid, 0);
        step();
        chk("add_lat_e1", out_valid, 0);
        step();
        chk("add_lat_e2", out_valid, 1);
        step();
        chk("add_pulse_end", out_valid, 0);

        // SUB waiting on tag 9, woken two cycles later
        disp(OP_SUB, 0, 1, 1, 4'd9, 0, 0, 4'd4, 0, 1);
        push(4'd4, 32'd9, 0, 0);
        step(); idle();
        step();
        cdb(4'd9, 32'd10);
        step(); idle();
        chk("wake_e0", out_valid, 0);
        step();
        chk("wake_issue_edge", out_valid, 0);
        step();
        chk("wake_out", out_valid, 1);
        step();

        // dispatch with simultaneous CDB forward
        disp(OP_SUB, 0, 1, 1, 4'd9, 0, 0, 4'd5, 0, 1);
        cdb(4'd9, 32'd20);
        push(4'd5, 32'd19, 0, 0);
        step(); idle();
        step();
        chk("fwd_e1", out_valid, 0);
        step();
        chk("fwd_out", out_valid, 1);
        step();

        // fill all four entries on tag 2; fifth dispatch dropped
        chk("fill_full0", full, 0);
        for (int i = 0; i < 4; i++) begin
            disp(OP_ADD, 0, i, 1, 4'd2, 0, 0, 4'(8 + i), 0, 1);
            push(4'(8 + i), 32'(100 + i), 0, 0);
            step();
        end
        chk("fill_full1", full, 1);
        disp(OP_ADD, 1, 1, 0, 0, 0, 0, 4'd12, 0, 1);
        step(); idle();
        chk("fill_full_hold", full, 1);
        cdb(4'd2, 32'd100);
        step(); idle();
        chk("fill_wake", out_valid, 0);
        step();
        chk("fill_full_freed", full, 0);
        chk("fill_issue0", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_back2back", out_valid, 1);
        end
        step();
        chk("fill_done", out_valid, 0);

        // JALR and two back-to-back branches
        disp(OP_JALR, 32'h1001, 32'd4, 0, 0, 0, 0, 4'd6, 32'h100, 1);
        push(4'd6, 32'h104, 1, 32'h1004);
        step();
        disp(OP_BEQ, 7, 7, 0, 0, 0, 0, 4'd7, 32'h200, 1);
        push(4'd7, 32'd1, 0, 0);
        step();
        disp(OP_BEQ, 7, 8, 0, 0, 0, 0, 4'd8, 32'h204, 1);
        push(4'd8, 32'd0, 0, 0);
        step(); idle();
        repeat (4) step();

        // flush with three waiting entries and one executing
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 0, 0, 1, 4'd7, 0, 0, 4'(1 + i), 0, 1);
            step();
        end
        disp(OP_ADD, 2, 2, 0, 0, 0, 0, 4'd4, 0, 1);
        step(); idle();
        chk("flush_pre_full", full, 1);
        step();
        flush = 1'b1;
        step(); idle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_full", full, 0);
        cdb(4'd7, 32'd1);
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_quiet", out_valid, 0);
        end

        // rdy_in low for three cycles while an op is executing
        disp(OP_ADD, 3, 4, 0, 0, 0, 0, 4'd13, 0, 1);
        push(4'd13, 32'd7, 0, 0);
        step(); idle();
        step();
        rdy_in = 1'b0;
        disp(OP_ADD, 9, 9, 0, 0, 0, 0, 4'd14, 0, 1);
        cdb(4'd7, 32'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_out_valid", out_valid, 0);
            chk("frz_alu_op1", alu_op1, 3);
            chk("frz_full", full, 0);
        end
        idle();
        rdy_in = 1'b1;
        step();
        chk("frz_resume_out", out_valid, 1);
        step();
        chk("frz_resume_end", out_valid, 0);

        // drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
